// File: rtl/bet_pkg.sv
// Shared balanced-ternary (BET) encodings and converter FSM states.
// Used by both the binary-to-BET and the BET-to-binary converters.
package bet_pkg;

    localparam logic [1:0] BET_NEG  = 2'b01;
    localparam logic [1:0] BET_ZERO = 2'b11;
    localparam logic [1:0] BET_POS  = 2'b10;
    localparam logic [1:0] BET_INV  = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } bet_state_e;

endpackage

// File: rtl/bet_trit_decode.sv
// Decodes one BET trit code into a signed value in {-1,0,+1} plus an invalid flag.
// Combinational: zero latency, no flow control.
module bet_trit_decode
    import bet_pkg::*;
(
    input  logic [1:0]        trit_i,
    output logic signed [1:0] val_o,
    output logic              inv_o
);

    always_comb begin
        val_o = '0;
        inv_o = 1'b0;
        case (trit_i)
            BET_NEG:  val_o = 2'b11;
            BET_POS:  val_o = 2'b01;
            BET_ZERO: val_o = 2'b00;
            default:  inv_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/bet_to_bin_serial.sv
// Serial BET-to-binary converter: trits arrive MSB-first and are folded Horner-style (acc = 3*acc + t).
// Result is valid the cycle after the last trit is accepted; input stalls (in_ready=0) until the result is taken.
module bet_to_bin_serial
    import bet_pkg::*;
#(
    parameter int N_TRITS = 4,
    parameter int OUT_W   = 7,
    parameter int CNT_W   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              trit_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_err
);

    localparam bit SINGLE_TRIT = (N_TRITS == 1);

    bet_state_e              state_q, state_d;
    logic signed [OUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic signed [1:0]       trit_val;
    logic                    trit_inv;
    logic signed [OUT_W-1:0] trit_ext;
    logic                    accept;
    logic                    last_trit;

    bet_trit_decode u_decode (
        .trit_i (trit_in),
        .val_o  (trit_val),
        .inv_o  (trit_inv)
    );

    assign trit_ext  = {{(OUT_W-2){trit_val[1]}}, trit_val};
    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign out_data  = (state_q == DONE) ? acc_q : '0;
    assign out_err   = (state_q == DONE) ? err_q : 1'b0;
    assign accept    = in_valid && in_ready;
    assign last_trit = (cnt_q == CNT_W'(N_TRITS - 1));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = trit_ext;
                    cnt_d   = CNT_W'(1);
                    err_d   = trit_inv;
                    state_d = SINGLE_TRIT ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    // 3*acc built as shift-plus-add
                    acc_d = (acc_q <<< 1) + acc_q + trit_ext;
                    cnt_d = cnt_q + CNT_W'(1);
                    err_d = err_q | trit_inv;
                    if (last_trit) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_bet_to_bin_serial.sv
// Scoreboarded bench for bet_to_bin_serial: directed scenarios plus randomized words against a sum-of-powers model.
module tb_bet_to_bin_serial;

    localparam int N     = 4;
    localparam int OUT_W = 7;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [1:0]              trit_in;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_err;

    int checks = 0;
    int errors = 0;
    bit rand_ready = 0;

    int exp_val[$];
    int exp_err[$];

    bit prev_hold = 0;
    int prev_data = 0;
    int prev_err  = 0;

    bet_to_bin_serial #(.N_TRITS(N), .OUT_W(OUT_W), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .trit_in   (trit_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int p3(input int e);
        int r = 1;
        for (int k = 0; k < e; k++) r = r * 3;
        return r;
    endfunction

    function automatic int ref_val(input logic [2*N-1:0] w);
        int v = 0;
        for (int i = 0; i < N; i++) begin
            logic [1:0] c;
            int t;
            c = w[2*(N-1-i) +: 2];
            t = (c == 2'b10) ? 1 : (c == 2'b01) ? -1 : 0;
            v = v + t * p3(N - 1 - i);
        end
        return v;
    endfunction

    function automatic int ref_err(input logic [2*N-1:0] w);
        int e = 0;
        for (int i = 0; i < N; i++) begin
            logic [1:0] c;
            c = w[2*(N-1-i) +: 2];
            if (c == 2'b00) e = 1;
        end
        return e;
    endfunction

    // Inputs change only just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_trit(input logic [1:0] c);
        bit ok = 0;
        int n = 0;
        in_valid = 1'b1;
        trit_in  = c;
        while (!ok) begin
            @(negedge clk);
            ok = in_ready;
            step();
            n++;
            if (!ok && n > 50) begin
                chk("accept_timeout", 0, 1);
                ok = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [2*N-1:0] w, input int maxgap, input bit push);
        if (push) begin
            exp_val.push_back(ref_val(w));
            exp_err.push_back(ref_err(w));
        end
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, maxgap)) begin
                in_valid = 1'b0;
                trit_in  = 2'($urandom);
                step();
            end
            send_trit(w[2*(N-1-i) +: 2]);
        end
        @(negedge clk);
        chk("valid_after_last_accept", int'(out_valid), 1);
        step();
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks DONE-state invariants.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready_vs_out_valid", int'(in_ready), int'(!out_valid));
            if (prev_hold) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data", int'(out_data), prev_data);
                chk("hold_err", int'(out_err), prev_err);
            end
            if (out_valid && out_ready) begin
                if (exp_val.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    chk("out_data", int'(out_data), exp_val.pop_front());
                    chk("out_err", int'(out_err), exp_err.pop_front());
                end
            end
        end
        prev_hold = out_valid && !out_ready && !rst;
        prev_data = int'(out_data);
        prev_err  = int'(out_err);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2*N-1:0] w;
        int n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        trit_in   = 2'b00;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_out_err", int'(out_err), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        step();

        // +1,0,-1,+1 -> 25; valid for exactly one cycle
        out_ready = 1'b1;
        send_word(8'b10_11_01_10, 0, 1);
        @(negedge clk);
        chk("single_cycle_valid", int'(out_valid), 0);
        step();

        // extremes back to back
        send_word(8'b01_01_01_01, 0, 1);
        send_word(8'b10_10_10_10, 0, 1);

        // backpressure with a trit held on the input
        out_ready = 1'b0;
        send_word(8'b11_11_11_10, 0, 1);
        in_valid = 1'b1;
        trit_in  = 2'b10;
        repeat (5) begin
            @(negedge clk);
            chk("held_valid", int'(out_valid), 1);
            chk("held_data", int'(out_data), 1);
            chk("held_in_ready", int'(in_ready), 0);
            step();
        end
        out_ready = 1'b1;
        send_word(8'b10_11_11_11, 0, 1);

        // invalid trit with gaps, then a clean word clears the error
        send_word(8'b10_00_11_01, 3, 1);
        send_word(8'b10_10_10_10, 2, 1);

        // reset mid-word discards the partial value
        send_trit(2'b10);
        send_trit(2'b01);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midword_rst_valid", int'(out_valid), 0);
        chk("midword_rst_in_ready", int'(in_ready), 1);
        step();
        send_word(8'b11_11_10_01, 1, 1);

        // reset wins over a same-cycle output handshake
        out_ready = 1'b0;
        send_word(8'b10_10_11_01, 0, 0);
        rst       = 1'b1;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("done_rst_valid", int'(out_valid), 0);
        chk("done_rst_data", int'(out_data), 0);
        chk("done_rst_in_ready", int'(in_ready), 1);
        chk("done_rst_no_pending", exp_val.size(), 0);
        step();

        // randomized words with random output backpressure
        rand_ready = 1;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) w[2*i +: 2] = 2'b00;
                else                           w[2*i +: 2] = 2'($urandom_range(1, 3));
            end
            send_word(w, 2, 1);
        end
        rand_ready = 0;
        out_ready  = 1'b1;
        n = 0;
        while (exp_val.size() != 0 && n < 20) begin
            step();
            n++;
        end
        @(negedge clk);
        chk("scoreboard_drained", exp_val.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bet_to_bin_serial.md
Name: bet_to_bin_serial

Overview:
- Serial radix converter: binary-encoded balanced-ternary (BET) word, received one trit per handshake MSB-first, to a two's-complement binary integer.
- Inverse of the binary-to-BET gate path. Sits at the ternary-to-binary boundary of a mixed-radix datapath.
- Accumulates Horner-style (acc = 3*acc + t) and presents the result on a valid/ready output with an error flag.

Parameters:
- N_TRITS, 4, trits per word (>=1)
- OUT_W, 7, signed output width; must satisfy 2^(OUT_W-1) > (3^N_TRITS - 1)/2 (N_TRITS=4 gives range +/-40, so 7 bits)
- CNT_W, 3, trit counter width; must satisfy 2^CNT_W > N_TRITS

Ports:
- clk, input, 1, single clock, rising edge
- rst, input, 1, reset, synchronous, active-high
- in_valid, input, 1, trit_in is valid
- in_ready, output, 1, block accepts a trit this cycle
- trit_in, input, 2, BET trit: 2'b01 = -1, 2'b11 = 0, 2'b10 = +1, 2'b00 = invalid
- out_valid, output, 1, result valid
- out_ready, input, 1, consumer accepts result
- out_data, output, OUT_W, signed two's-complement result
- out_err, output, 1, at least one invalid trit occurred in this word

Behaviour:
- Reset: rst=1 at a clock edge forces the following, overriding any handshake in the same cycle:
  - state=IDLE, acc=0, cnt=0, err=0
  - out_valid=0, out_data=0, out_err=0
  - in_ready=1 after reset
- A trit is accepted on a clock edge where in_valid && in_ready.
- Trit decode: -1/0/+1 sign-extended to OUT_W. Invalid code 2'b00 decodes as 0 and sets the sticky err.
- IDLE:
  - in_ready=1.
  - On accept: acc <= t, cnt <= 1, err <= invalid(trit_in).
  - If N_TRITS==1, go to DONE; otherwise go to ACCUM.
- ACCUM:
  - in_ready=1.
  - On accept: acc <= (acc<<1) + acc + t, cnt <= cnt+1, err <= err | invalid.
  - When the accepted trit is trit number N_TRITS, go to DONE.
  - No accept: hold everything. Gaps in in_valid are allowed, with no timeout.
- DONE:
  - in_ready=0, out_valid=1, out_data=acc, out_err=err.
  - Values are held stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE, clear acc, cnt and err.
  - in_ready returns to 1 the cycle after the output handshake. No same-cycle new-frame accept.
- Latency: out_valid rises on the clock edge that accepts the last trit, i.e. it is visible the cycle after that accept. Peak throughput is one word per N_TRITS+1 cycles.
- Arithmetic:
  - All arithmetic is signed OUT_W-bit.
  - With legal parameters no overflow occurs; no saturation logic.
  - Value = sum of t_i*3^(N-1-i), with i=0 the first trit received.
- Boundaries:
  - in_valid asserted in DONE is ignored; the trit is not consumed, since in_ready=0.
  - trit_in may change freely while in_valid=0.
  - Reset mid-word discards the partial word; the next accepted trit is treated as the MSB.
- Mealy paths: none. in_ready and out_valid are pure functions of state.

Decomposition:
- Package bet_pkg:
  - BET_NEG=2'b01, BET_ZERO=2'b11, BET_POS=2'b10, BET_INV=2'b00
  - state enum {IDLE, ACCUM, DONE}
  - Shared with the binary-to-BET converters.
- Sub-module bet_trit_decode:
  - Combinational. 2-bit trit in -> signed 2-bit value + invalid flag.
  - Reused by other BET consumers.
- Top holds the FSM, counter and accumulator.

Test Plan:
- Trits +1,0,-1,+1 (2'b10,2'b11,2'b01,2'b10) back-to-back, out_ready=1 -> out_data=25, out_err=0; out_valid high exactly 1 cycle, starting 1 cycle after the 4th accept.
- All four trits -1, then all four +1 -> out_data=-40 (7'b1011000), then +40; in_ready=0 during each DONE cycle.
- Word 0,0,0,+1 with out_ready=0 for 5 cycles -> out_data=1 held stable with out_valid=1 for 5 cycles. in_valid held high throughout is not consumed. Release out_ready -> IDLE, and the held trit is accepted the next cycle as a new MSB.
- Trits +1,2'b00,0,-1 with in_valid gaps -> out_data=26 (27+0+0-1), out_err=1. Next clean word +1,+1,+1,+1 -> out_data=40, out_err=0 (err cleared).
- Two trits accepted, rst=1 for 1 cycle -> out_valid=0, in_ready=1. Then trits 0,0,+1,-1 -> out_data=2 with no residue from the aborted word.
- rst asserted while in DONE with out_ready=1 in the same cycle -> no output handshake, state=IDLE, out_data=0.
